// File: rtl/cstretch_pkg.sv
// Shared constants and FSM state type for the contrast-stretch block.
// Optional feature macro: CSTRETCH_BYPASS_EN (adds the i_bypass port).
package cstretch_pkg;

    localparam int unsigned CS_DW    = 8;
    localparam int unsigned CS_FRAC  = 8;
    localparam int unsigned GW       = CS_DW + CS_FRAC;
    localparam logic [CS_DW-1:0] FS  = '1;
    localparam logic [GW-1:0] GAIN_ONE = GW'(1) << CS_FRAC;
    localparam logic [GW-1:0] RND      = GW'(1) << (CS_FRAC - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        COMMIT
    } cs_state_e;

endpackage

// File: rtl/contrast_stretch_if.sv
// Video stream bundle: pixel/sync inputs toward the block, stretched pixel/syncs back.
interface contrast_stretch_if #(
    parameter int unsigned DW = 8
);

    logic [DW-1:0] din;
    logic          i_hsync;
    logic          i_vsync;
    logic          i_de;
    logic [DW-1:0] dout;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;

    modport master (
        output din, i_hsync, i_vsync, i_de,
        input  dout, o_hsync, o_vsync, o_de
    );

    modport slave (
        input  din, i_hsync, i_vsync, i_de,
        output dout, o_hsync, o_vsync, o_de
    );

endinterface

// File: rtl/cstretch_div.sv
// Serial restoring divider: one quotient bit per cycle, NW cycles per divide.
// A start pulse reloads the operands, aborting any divide in flight.
module cstretch_div #(
    parameter int unsigned NW  = 16,
    parameter int unsigned DVW = 8
) (
    input  logic           pixelclk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [NW-1:0]  dividend,
    input  logic [DVW-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [NW-1:0]  quotient
);

    localparam int unsigned CW = $clog2(NW);

    logic [NW-1:0]  dvd_q, dvd_d;
    logic [NW-1:0]  quo_q, quo_d;
    logic [DVW-1:0] dsr_q, dsr_d;
    logic [DVW-1:0] rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [DVW:0]   rem_sh;
    logic [DVW:0]   rem_sub;

    // Next-state: load on start, otherwise shift one dividend bit into the remainder
    always_comb begin
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rem_sh  = {rem_q, dvd_q[NW-1]};
        rem_sub = rem_sh - {1'b0, dsr_q};
        if (start) begin
            dvd_d  = dividend;
            dsr_d  = divisor;
            rem_d  = '0;
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            dvd_d = dvd_q << 1;
            if (rem_sh >= {1'b0, dsr_q}) begin
                rem_d = rem_sub[DVW-1:0];
                quo_d = {quo_q[NW-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DVW-1:0];
                quo_d = {quo_q[NW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NW - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CW'(NW - 1));
    assign quotient = quo_q;

endmodule

// File: rtl/contrast_stretch.sv
// Contrast stretch: latches per-frame min/max at vsync rise, derives the gain
// FS<<FRAC / (max-min) with a serial divider, and remaps pixels through a
// 3-stage pipeline with syncs delayed to match.
// Optional feature macro: CSTRETCH_BYPASS_EN (i_bypass passes pixels unchanged).
module contrast_stretch
    import cstretch_pkg::*;
#(
    parameter int unsigned DW   = CS_DW,
    parameter int unsigned FRAC = CS_FRAC
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    contrast_stretch_if.slave vid,
    input  logic [DW-1:0] gray_min,
    input  logic [DW-1:0] gray_max
`ifdef CSTRETCH_BYPASS_EN
    ,
    input  logic          i_bypass
`endif
);

    localparam int unsigned GW_L = DW + FRAC;
    localparam int unsigned PW_L = DW + GW_L;
    localparam int unsigned RW_L = PW_L - FRAC + 1;
    localparam logic [DW-1:0]   FS_L   = '1;
    localparam logic [GW_L-1:0] ONE_L  = GW_L'(1) << FRAC;
    localparam logic [PW_L:0]   RND_L  = (PW_L + 1)'(1) << (FRAC - 1);
    localparam logic [GW_L-1:0] DVD_L  = {FS_L, {FRAC{1'b0}}};

    // Gain FSM state
    cs_state_e       state_q;
    logic            vsync_r_q;
    logic            div_start_q;
    logic            ident_q;
    logic            de_seen_q;
    logic [DW-1:0]   min_l_q;
    logic [DW-1:0]   range_q;
    logic [GW_L-1:0] gain_q;
    logic [DW-1:0]   min_q;
    logic            vs_rise;

    logic            div_busy;
    logic            div_done;
    logic [GW_L-1:0] div_quo;

    // Datapath state
    logic [DW-1:0]   diff_q;
    logic [PW_L-1:0] prod_q;
    logic [DW-1:0]   dout_q, dout_d;
    logic [2:0]      hs_q, vs_q, de_q;
    logic [PW_L:0]   rsum;
    logic [RW_L-1:0] r;
`ifdef CSTRETCH_BYPASS_EN
    logic [1:0]      byp_q;
    logic [DW-1:0]   dly1_q, dly2_q;
`endif

    assign vs_rise = vid.i_vsync & ~vsync_r_q;

    cstretch_div #(
        .NW  (GW_L),
        .DVW (DW)
    ) u_div (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .start    (div_start_q),
        .dividend (DVD_L),
        .divisor  (range_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Stats are captured on the rise edge itself so the divider can start
    // in LOAD; that keeps the whole update inside GW+3 cycles of vblank.
    // Gain FSM: latch stats, divide, commit only if the frame has no pixel yet
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vsync_r_q   <= 1'b0;
            div_start_q <= 1'b0;
            ident_q     <= 1'b1;
            de_seen_q   <= 1'b0;
            min_l_q     <= '0;
            range_q     <= '0;
            gain_q      <= ONE_L;
            min_q       <= '0;
        end else begin
            vsync_r_q   <= vid.i_vsync;
            div_start_q <= 1'b0;
            de_seen_q   <= de_seen_q | vid.i_de;
            if (vs_rise) begin
                state_q     <= LOAD;
                min_l_q     <= gray_min;
                range_q     <= gray_max - gray_min;
                ident_q     <= (gray_max <= gray_min);
                div_start_q <= (gray_max > gray_min);
                de_seen_q   <= vid.i_de;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    LOAD: begin
                        state_q <= ident_q ? COMMIT : DIV;
                    end
                    DIV: begin
                        if (div_done) begin
                            state_q <= COMMIT;
                        end else if (!div_busy) begin
                            state_q <= IDLE;
                        end
                    end
                    COMMIT: begin
                        if (!de_seen_q && !vid.i_de) begin
                            gain_q <= ident_q ? ONE_L : div_quo;
                            min_q  <= ident_q ? '0 : min_l_q;
                        end
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // S1: offset removal, clamped at zero
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            diff_q <= '0;
        end else begin
            diff_q <= (vid.din < min_q) ? '0 : (vid.din - min_q);
        end
    end

    // S2: scale by the active gain
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= PW_L'(diff_q) * PW_L'(gain_q);
        end
    end

    assign rsum = {1'b0, prod_q} + RND_L;
    assign r    = rsum[PW_L:FRAC];

    // S3 next value: round, saturate, blank outside active video
    always_comb begin
        dout_d = '0;
        if (de_q[1]) begin
`ifdef CSTRETCH_BYPASS_EN
            if (byp_q[1]) begin
                dout_d = dly2_q;
            end else
`endif
            if (r > {{(RW_L - DW){1'b0}}, FS_L}) begin
                dout_d = FS_L;
            end else begin
                dout_d = r[DW-1:0];
            end
        end
    end

    // S3 output register and sync delay line
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            hs_q   <= '0;
            vs_q   <= '0;
            de_q   <= '0;
        end else begin
            dout_q <= dout_d;
            hs_q   <= {hs_q[1:0], vid.i_hsync};
            vs_q   <= {vs_q[1:0], vid.i_vsync};
            de_q   <= {de_q[1:0], vid.i_de};
        end
    end

`ifdef CSTRETCH_BYPASS_EN
    // Bypass flag and raw pixel travel alongside S1/S2
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            byp_q  <= '0;
            dly1_q <= '0;
            dly2_q <= '0;
        end else begin
            byp_q  <= {byp_q[0], i_bypass};
            dly1_q <= vid.din;
            dly2_q <= dly1_q;
        end
    end
`endif

    assign vid.dout    = dout_q;
    assign vid.o_hsync = hs_q[2];
    assign vid.o_vsync = vs_q[2];
    assign vid.o_de    = de_q[2];

endmodule

// File: tb/tb_contrast_stretch.sv
// Directed bench for contrast_stretch with hand-computed pixel results.
// Build with CSTRETCH_BYPASS_EN defined to include the bypass vectors.
module tb_contrast_stretch;
    import cstretch_pkg::*;

    logic       pixelclk;
    logic       reset_n;
    logic [7:0] gray_min;
    logic [7:0] gray_max;
`ifdef CSTRETCH_BYPASS_EN
    logic       byp;
`endif

    contrast_stretch_if #(.DW(8)) vid ();

    contrast_stretch #(
        .DW   (8),
        .FRAC (8)
    ) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .vid      (vid),
        .gray_min (gray_min),
        .gray_max (gray_max)
`ifdef CSTRETCH_BYPASS_EN
        ,
        .i_bypass (byp)
`endif
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned n_step;
    logic [7:0]  h_dout [4];
    logic        h_hs   [4];
    logic        h_vs   [4];
    logic        h_de   [4];
    logic        h_chk  [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    // One pixel clock: drive inputs at a negedge, then check the entry
    // that has just emerged from the 3-cycle pipeline.
    task automatic step(input logic [7:0] d, input logic h, input logic v,
                        input logic de, input logic [7:0] e, input logic chk);
        int unsigned idx;
        vid.din     = d;
        vid.i_hsync = h;
        vid.i_vsync = v;
        vid.i_de    = de;
        idx = n_step % 4;
        h_dout[idx] = e;
        h_hs[idx]   = h;
        h_vs[idx]   = v;
        h_de[idx]   = de;
        h_chk[idx]  = chk;
        @(negedge pixelclk);
        if (n_step >= 2) begin
            idx = (n_step - 2) % 4;
            if (h_chk[idx]) begin
                check("dout",    vid.dout,    h_dout[idx]);
                check("o_hsync", vid.o_hsync, h_hs[idx]);
                check("o_vsync", vid.o_vsync, h_vs[idx]);
                check("o_de",    vid.o_de,    h_de[idx]);
            end
        end
        n_step++;
    endtask

    task automatic idle(input int unsigned n, input logic v);
        repeat (n) step(8'd0, 1'b0, v, 1'b0, 8'd0, 1'b0);
    endtask

    // Vsync low for two cycles, then rise followed by nidle blank cycles
    task automatic frame(input logic [7:0] mn, input logic [7:0] mx, input int unsigned nidle);
        gray_min = mn;
        gray_max = mx;
        idle(2, 1'b0);
        idle(nidle, 1'b1);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_step = 0;
        for (int i = 0; i < 4; i++) h_chk[i] = 1'b0;
        reset_n     = 1'b0;
        gray_min    = '0;
        gray_max    = '0;
        vid.din     = '0;
        vid.i_hsync = 1'b1;
        vid.i_vsync = 1'b1;
        vid.i_de    = 1'b1;
`ifdef CSTRETCH_BYPASS_EN
        byp = 1'b0;
`endif
        repeat (3) @(negedge pixelclk);
        check("rst_dout",  vid.dout,    0);
        check("rst_hsync", vid.o_hsync, 0);
        check("rst_vsync", vid.o_vsync, 0);
        check("rst_de",    vid.o_de,    0);
        reset_n = 1'b1;

        // 1: identity before any frame, syncs delayed by 3
        step(8'd100, 1'b1, 1'b0, 1'b1, 8'd100, 1'b1);
        step(8'd100, 1'b0, 1'b0, 1'b1, 8'd100, 1'b1);
        step(8'd200, 1'b1, 1'b0, 1'b1, 8'd200, 1'b1);
        step(8'd7,   1'b0, 1'b0, 1'b1, 8'd7,   1'b1);
        idle(3, 1'b0);

        // 2: min=50, max=150 -> gain 652
        frame(8'd50, 8'd150, 40);
        step(8'd100, 1'b1, 1'b1, 1'b1, 8'd127, 1'b1);
        step(8'd150, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
        step(8'd40,  1'b1, 1'b1, 1'b1, 8'd0,   1'b1);
        step(8'd200, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
        step(8'd50,  1'b0, 1'b1, 1'b1, 8'd0,   1'b1);
        step(8'd51,  1'b0, 1'b1, 1'b1, 8'd3,   1'b1);
        step(8'd200, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1);
`ifdef CSTRETCH_BYPASS_EN
        byp = 1'b1;
        step(8'd100, 1'b0, 1'b1, 1'b1, 8'd100, 1'b1);
        step(8'd30,  1'b0, 1'b1, 1'b1, 8'd30,  1'b1);
        byp = 1'b0;
        step(8'd100, 1'b0, 1'b1, 1'b1, 8'd127, 1'b1);
`endif
        idle(3, 1'b1);

        // 4: min=max -> identity committed
        frame(8'd80, 8'd80, 40);
        step(8'd37,  1'b0, 1'b1, 1'b1, 8'd37,  1'b1);
        step(8'd200, 1'b1, 1'b1, 1'b1, 8'd200, 1'b1);
        idle(3, 1'b1);

        // 3: full range -> gain 256, ramp passes unchanged
        frame(8'd0, 8'd255, 40);
        for (int i = 0; i <= int'(FS); i++) begin
            step(8'(i), 1'b0, 1'b1, 1'b1, 8'(i), 1'b1);
        end
        idle(3, 1'b1);

        // 5: pixels too early -> previous (identity) gain kept for the frame
        frame(8'd50, 8'd150, 5);
        step(8'd100, 1'b0, 1'b1, 1'b1, 8'd100, 1'b1);
        step(8'd40,  1'b0, 1'b1, 1'b1, 8'd40,  1'b1);
        idle(20, 1'b1);
        step(8'd100, 1'b0, 1'b1, 1'b1, 8'd100, 1'b1);
        idle(3, 1'b1);
        // first pixel one cycle short of the update window: still discarded
        frame(8'd50, 8'd150, GW + 2);
        step(8'd100, 1'b0, 1'b1, 1'b1, 8'd100, 1'b1);
        idle(3, 1'b1);
        // first pixel exactly at the window edge: new gain applies
        frame(8'd50, 8'd150, GW + 3);
        step(8'd100, 1'b0, 1'b1, 1'b1, 8'd127, 1'b1);
        step(8'd200, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
        idle(3, 1'b1);

        // 6: reset in the middle of a divide
        gray_min = 8'd60;
        gray_max = 8'd160;
        idle(2, 1'b0);
        repeat (8) step(8'd200, 1'b1, 1'b1, 1'b1, 8'd255, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_dout",  vid.dout,    0);
        check("midrst_hsync", vid.o_hsync, 0);
        check("midrst_vsync", vid.o_vsync, 0);
        check("midrst_de",    vid.o_de,    0);
        for (int i = 0; i < 4; i++) h_chk[i] = 1'b0;
        idle(3, 1'b0);
        reset_n = 1'b1;
        idle(2, 1'b0);
        step(8'd100, 1'b1, 1'b0, 1'b1, 8'd100, 1'b1);
        step(8'd40,  1'b0, 1'b0, 1'b1, 8'd40,  1'b1);
        idle(3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
